fft_load_sequencer: RTL
=======================

FFT_LOAD_SEQUENCER -- requirements
Module: fft_load_sequencer

Interface
REQ-001 SHALL have parameter SAMPLES, default 8, giving the frame length in samples; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter WIDTH, default 3, giving the sample width in bits.
REQ-003 SHALL derive ADDR = $clog2(SAMPLES) for the index and pointer widths.
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous abort of the current frame.
REQ-008 in_valid  input  1  input sample present.
REQ-009 in_ready  output  1  block accepts an input sample.
REQ-010 in_data  input  WIDTH  time-order input sample.
REQ-011 out_valid  output  1  reordered sample present.
REQ-012 out_ready  input  1  downstream FFT accepts the output sample.
REQ-013 out_data  output  WIDTH  bit-reversed-order sample.
REQ-014 out_index  output  ADDR  output slot number, 0..SAMPLES-1.
REQ-015 out_last  output  1  asserted with the final sample of a frame.
REQ-016 frame_count  output  8  count of fully drained frames.

Function
REQ-017 SHALL contain a SAMPLES x WIDTH register buffer, a write counter wr_cnt (ADDR bits) and a read pointer rd_ptr (ADDR bits).
REQ-018 SHALL implement a two-state FSM with states LOAD and DRAIN.
REQ-019 In LOAD, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-020 In DRAIN, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-021 A transfer SHALL occur on a rising edge where valid and ready are both 1; data SHALL be held unchanged while valid=1 and ready=0.
REQ-022 In LOAD, on an input transfer, SHALL write in_data to buffer[bitrev(wr_cnt)], where bitrev reverses the ADDR bits, and SHALL increment wr_cnt.
REQ-023 On the input transfer with wr_cnt = SAMPLES-1, SHALL move to DRAIN, clear wr_cnt and clear rd_ptr; out_valid SHALL be 1 on the next cycle (1-cycle latency from the last input).
REQ-024 In DRAIN: out_data = buffer[rd_ptr], out_index = rd_ptr, out_last = (rd_ptr == SAMPLES-1).
REQ-025 In DRAIN, on an output transfer, SHALL increment rd_ptr.
REQ-026 On the output transfer with out_last=1, SHALL return to LOAD, clear rd_ptr and increment frame_count.
REQ-027 frame_count SHALL wrap from 255 to 0.
REQ-028 Input and output phases SHALL NOT overlap; no sample is accepted while draining.
REQ-029 flush=1 SHALL, on the next edge, force LOAD and clear wr_cnt and rd_ptr, taking priority over any simultaneous transfer; buffer contents and frame_count SHALL be retained.
REQ-030 A frame aborted by flush SHALL NOT increment frame_count.
REQ-031 Outputs out_index and out_last SHALL be 0 whenever out_valid is 0.

Reset
REQ-032 reset=1 SHALL immediately force LOAD, wr_cnt=0, rd_ptr=0, frame_count=0, out_valid=0, out_last=0, out_index=0.
REQ-033 During reset, in_ready SHALL be 0; it SHALL be 1 from the first clock edge after reset deasserts.
REQ-034 Buffer contents need not be reset; out_data SHALL be ignored while out_valid=0.
REQ-035 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the partial frame, with no output and no count increment.

Verification
REQ-036 Basic frame: in_valid held high with inputs 5,3,6,2,7,1,0,4 and out_ready=1 -> outputs 5,7,6,0,3,1,2,4 with out_index 0..7, out_last only on 4, frame_count=1.
REQ-037 Backpressure: same frame with out_ready toggling 1,0,0,1,... -> identical output sequence, and out_data/out_index stable while stalled.
REQ-038 Input gaps: in_valid low on alternate cycles -> same output order; DRAIN is entered exactly 1 cycle after the 8th accept.
REQ-039 Flush: flush after 5 accepted inputs, then a fresh frame 0..7 -> outputs 0,4,2,6,1,5,3,7 and frame_count=1; also flush during DRAIN at rd_ptr=3 -> returns to LOAD with no count increment.
REQ-040 Reset mid-DRAIN: assert reset at rd_ptr=2 -> out_valid falls immediately and frame_count=0; the next frame reorders correctly.
REQ-041 Counter wrap: 256 back-to-back frames -> frame_count returns to 0 and in_ready is never 1 during DRAIN.

Source files
------------

// File: rtl/fft_load_sequencer.sv
// Collects one frame of time-order samples into a register buffer at
// bit-reversed addresses, then drains it in linear order for a radix-2 FFT.
module fft_load_sequencer #(
    parameter int SAMPLES = 8,
    parameter int WIDTH   = 3,
    localparam int ADDR   = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [ADDR-1:0]  out_index,
    output logic             out_last,
    output logic [7:0]       frame_count
);

    localparam logic [0:0] LOAD  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    localparam logic [ADDR-1:0] LAST_IDX = ADDR'(SAMPLES - 1);

    logic [0:0]       state_reg;
    logic [ADDR-1:0]  wr_cnt_reg;
    logic [ADDR-1:0]  rd_ptr_reg;
    logic [7:0]       frame_count_reg;
    logic             run_reg;
    logic [ADDR-1:0]  wr_addr;
    logic [WIDTH-1:0] buffer [SAMPLES];
    logic             in_fire;
    logic             out_fire;

    // Write address is the write counter with its bits mirrored.
    generate
        for (genvar gi = 0; gi < ADDR; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_cnt_reg[ADDR-1-gi];
        end
    endgenerate

    // run_reg keeps in_ready low while reset is held and until the first edge after it.
    assign in_ready    = run_reg && (state_reg == LOAD);
    assign out_valid   = (state_reg == DRAIN);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign out_data    = buffer[rd_ptr_reg];
    assign out_index   = out_valid ? rd_ptr_reg : '0;
    assign out_last    = out_valid && (rd_ptr_reg == LAST_IDX);
    assign frame_count = frame_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= LOAD;
            wr_cnt_reg      <= '0;
            rd_ptr_reg      <= '0;
            frame_count_reg <= '0;
            run_reg         <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (flush) begin
                state_reg  <= LOAD;
                wr_cnt_reg <= '0;
                rd_ptr_reg <= '0;
            end else if (state_reg == LOAD) begin
                if (in_fire) begin
                    if (wr_cnt_reg == LAST_IDX) begin
                        state_reg  <= DRAIN;
                        wr_cnt_reg <= '0;
                        rd_ptr_reg <= '0;
                    end else begin
                        wr_cnt_reg <= wr_cnt_reg + ADDR'(1);
                    end
                end
            end else begin
                if (out_fire) begin
                    if (rd_ptr_reg == LAST_IDX) begin
                        state_reg       <= LOAD;
                        rd_ptr_reg      <= '0;
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end else begin
                        rd_ptr_reg <= rd_ptr_reg + ADDR'(1);
                    end
                end
            end
        end
    end

    // Sample storage carries no reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (!flush && in_fire) begin
            buffer[wr_addr] <= in_data;
        end
    end

endmodule
